// File: rtl/bp_fe_icache_arbiter_if.sv
// Request-side bundle between the FE controller, the next-line prefetcher and the I$ packet port.
// The master modport is the FE/I$ environment; the slave modport is the arbiter itself.
interface bp_fe_icache_arbiter_if #(
    parameter int vaddr_width_p = 39,
    parameter int pf_fifo_els_p = 2
);
    localparam int count_width_lp = $clog2(pf_fifo_els_p + 1);

    logic                      demand_v_i;
    logic [vaddr_width_p-1:0]  demand_vaddr_i;
    logic                      demand_force_i;
    logic                      demand_yumi_o;
    logic                      pf_trigger_v_i;
    logic [vaddr_width_p-1:0]  pf_trigger_vaddr_i;
    logic                      flush_i;
    logic                      icache_v_o;
    logic [vaddr_width_p-1:0]  icache_vaddr_o;
    logic                      icache_spec_o;
    logic                      icache_yumi_i;
    logic                      pf_drop_o;
    logic [count_width_lp-1:0] pf_count_o;

    modport master (
        output demand_v_i, demand_vaddr_i, demand_force_i,
        output pf_trigger_v_i, pf_trigger_vaddr_i, flush_i, icache_yumi_i,
        input  demand_yumi_o, icache_v_o, icache_vaddr_o, icache_spec_o,
        input  pf_drop_o, pf_count_o
    );

    modport slave (
        input  demand_v_i, demand_vaddr_i, demand_force_i,
        input  pf_trigger_v_i, pf_trigger_vaddr_i, flush_i, icache_yumi_i,
        output demand_yumi_o, icache_v_o, icache_vaddr_o, icache_spec_o,
        output pf_drop_o, pf_count_o
    );
endinterface

// File: rtl/bp_fe_icache_arbiter.sv
// Shares the I$ request port between demand fetches and a small queue of next-line prefetches.
// Demand wins by default; a saturating starvation counter forces one prefetch out periodically.
module bp_fe_icache_arbiter #(
    parameter int vaddr_width_p  = 39,
    parameter int block_bytes_p  = 64,
    parameter int pf_fifo_els_p  = 2,
    parameter int starve_limit_p = 7
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_fe_icache_arbiter_if.slave    bus_if
);

    localparam int lc_ptr_w    = $clog2(pf_fifo_els_p);
    localparam int lc_cnt_w    = $clog2(pf_fifo_els_p + 1);
    localparam int lc_starve_w = $clog2(starve_limit_p + 1);

    localparam logic [vaddr_width_p-1:0] lc_block      = vaddr_width_p'(block_bytes_p);
    localparam logic [vaddr_width_p-1:0] lc_off_mask   = vaddr_width_p'(block_bytes_p - 1);
    localparam logic [lc_cnt_w-1:0]      lc_full       = lc_cnt_w'(pf_fifo_els_p);
    localparam logic [lc_starve_w-1:0]   lc_starve_max = lc_starve_w'(starve_limit_p);

    logic [vaddr_width_p-1:0] r_mem [pf_fifo_els_p];
    logic [lc_ptr_w-1:0]      r_rd_ptr;
    logic [lc_ptr_w-1:0]      r_wr_ptr;
    logic [lc_cnt_w-1:0]      r_count;
    logic [lc_starve_w-1:0]   r_starve;

    logic [vaddr_width_p-1:0] w_pf_vaddr;
    logic [vaddr_width_p-1:0] w_head_vaddr;
    logic [vaddr_width_p-1:0] w_last_vaddr;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_dup;
    logic                     w_sel_pf;
    logic                     w_pf_grant;
    logic                     w_dmd_grant;
    logic                     w_try_enq;
    logic                     w_enq;
    logic                     w_drop;
    logic [lc_cnt_w-1:0]      w_count_next;
    logic [lc_starve_w-1:0]   w_starve_next;

    // Next-line target: align down to the block, step one block; wrap past the top is legal.
    assign w_pf_vaddr   = (bus_if.pf_trigger_vaddr_i & ~lc_off_mask) + lc_block;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == lc_full);
    assign w_head_vaddr = r_mem[r_rd_ptr];
    assign w_last_vaddr = r_mem[r_wr_ptr - lc_ptr_w'(1)];

    // Only the youngest live entry is compared; an empty queue never suppresses.
    assign w_dup        = ~w_empty & (w_last_vaddr == w_pf_vaddr);

    assign w_sel_pf     = ~w_empty & ~bus_if.demand_force_i
                        & (~bus_if.demand_v_i | (r_starve == lc_starve_max));
    assign w_pf_grant   = bus_if.icache_yumi_i & w_sel_pf;
    assign w_dmd_grant  = bus_if.icache_yumi_i & ~w_sel_pf & bus_if.demand_v_i;

    // A full queue still takes the trigger when its head leaves in the same cycle.
    assign w_try_enq    = bus_if.pf_trigger_v_i & ~bus_if.flush_i & ~w_dup;
    assign w_enq        = w_try_enq & (~w_full | w_pf_grant);
    assign w_drop       = w_try_enq & w_full & ~w_pf_grant;

    assign w_count_next = bus_if.flush_i ? '0
                        : r_count + lc_cnt_w'(w_enq) - lc_cnt_w'(w_pf_grant);

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_starve_next = r_starve;
        if (bus_if.flush_i || w_pf_grant || (w_count_next == '0)) begin
            w_starve_next = '0;
        end else if (w_dmd_grant && !w_empty && (r_starve != lc_starve_max)) begin
            w_starve_next = r_starve + lc_starve_w'(1);
        end
    end

    // NOTE: queue storage has no reset; r_count alone says which slots hold live entries,
    // so clearing the data would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_pf_vaddr;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge
    // values and the update order inside the block does not matter.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            r_count  <= w_count_next;
            r_starve <= w_starve_next;
            if (bus_if.flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pf_grant) begin
                    r_rd_ptr <= r_rd_ptr + lc_ptr_w'(1);
                end
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + lc_ptr_w'(1);
                end
            end
        end
    end

    // Outputs are held quiet for the whole reset cycle, including the combinational demand path.
    always_comb begin
        bus_if.icache_v_o     = 1'b0;
        bus_if.icache_vaddr_o = bus_if.demand_vaddr_i;
        bus_if.icache_spec_o  = 1'b0;
        bus_if.demand_yumi_o  = 1'b0;
        bus_if.pf_drop_o      = 1'b0;
        bus_if.pf_count_o     = '0;
        if (reset_n_i) begin
            bus_if.pf_count_o    = r_count;
            bus_if.pf_drop_o     = w_drop;
            bus_if.demand_yumi_o = w_dmd_grant;
            if (w_sel_pf) begin
                bus_if.icache_v_o     = 1'b1;
                bus_if.icache_vaddr_o = w_head_vaddr;
                bus_if.icache_spec_o  = 1'b1;
            end else begin
                bus_if.icache_v_o     = bus_if.demand_v_i;
            end
        end
    end

endmodule

// File: doc/bp_fe_icache_arbiter.md
# bp_fe_icache_arbiter

Shares the single I$ request port between the demand fetch stream from the FE controller and next-line prefetches generated on I$ misses. Sits between the FE controller / PC generation logic and the I$ packet input. Demand requests win by default. A saturating starvation counter guarantees prefetch forward progress. Prefetches are issued as speculative fetches and can be flushed on any redirect.

## Interface
- vaddr_width_p, 39, virtual address width
- block_bytes_p, 64, I$ block size in bytes (power of two); next-line stride
- pf_fifo_els_p, 2, prefetch queue depth (power of two, ≥2)
- starve_limit_p, 7, demand grants tolerated with a non-empty queue before one prefetch is forced out
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- demand_v_i  in  1  demand fetch request valid
- demand_vaddr_i  in  vaddr_width_p  demand fetch PC
- demand_force_i  in  1  demand must win this cycle regardless of starvation (redirect/fill-response path)
- demand_yumi_o  out  1  demand request accepted by I$ this cycle
- pf_trigger_v_i  in  1  I$ miss observed; enqueue next-line prefetch
- pf_trigger_vaddr_i  in  vaddr_width_p  missing vaddr
- flush_i  in  1  discard all queued prefetches
- icache_v_o  out  1  request valid to I$
- icache_vaddr_o  out  vaddr_width_p  request vaddr
- icache_spec_o  out  1  request is speculative (1 for every prefetch, 0 for demand)
- icache_yumi_i  in  1  I$ accepts request, same cycle as icache_v_o
- pf_drop_o  out  1  pulse: trigger discarded because queue full
- pf_count_o  out  $clog2(pf_fifo_els_p+1)  occupancy, for perf counters

## Operation
- Prefetch address = (pf_trigger_vaddr_i & ~(block_bytes_p-1)) + block_bytes_p, truncated to vaddr_width_p bits. Wrap from the top block to 0 is legal.
- Enqueue on pf_trigger_v_i unless one of these holds:
  - flush_i is high: trigger silently discarded, no drop pulse.
  - Computed address equals the most recently enqueued entry still in the queue: suppressed, no drop pulse.
  - Queue is full and no dequeue happens this cycle: discarded, pf_drop_o=1.
- A full queue with a simultaneous dequeue accepts the trigger; occupancy stays at pf_fifo_els_p.
- Queue is FIFO, implemented as a circular buffer with separate read and write pointers that wrap modulo pf_fifo_els_p.
- Selection (combinational) each cycle:
  - sel_pf = queue non-empty & ~demand_force_i & (~demand_v_i | starve_cnt == starve_limit_p).
  - sel_pf=1: icache_v_o=1, vaddr = queue head, spec=1.
  - Otherwise: icache_v_o=demand_v_i, vaddr=demand_vaddr_i, spec=0.
- demand_yumi_o = icache_yumi_i & ~sel_pf & demand_v_i. Dequeue = icache_yumi_i & sel_pf.
- Starvation counter:
  - 0 when queue empty.
  - +1 on each demand grant while queue non-empty, saturating at starve_limit_p.
  - Cleared on a prefetch grant.
  - Cleared on flush_i.
- flush_i empties the queue at the clock edge. A prefetch granted in the same cycle is still issued (already accepted by I$).
- No internal request hold: demand may preempt an un-accepted prefetch in the next cycle, and I$ must not assume stability before yumi.

## Timing
- Reset (reset_n_i=0 at posedge): queue empty, pointers 0, starve_cnt 0.
- Outputs while in reset: icache_v_o=0, demand_yumi_o=0, pf_drop_o=0, pf_count_o=0, icache_spec_o=0.
- Demand path is zero-latency, combinational from demand_v_i/demand_vaddr_i to icache_*_o.
- A trigger enqueued at edge N is first eligible for issue in cycle N+1; there is no same-cycle bypass.
- pf_drop_o is combinational in the trigger cycle.
- pf_count_o is registered and reflects state after the previous edge.
- Reset asserted mid-operation discards queued entries and starvation state; no request is outstanding inside this block.

## Test plan
- Next-line arithmetic, including wrap:
  - Trigger vaddr 0x1234 with demand idle, then icache_yumi_i=1 → next cycle icache_v_o=1, vaddr=0x1240, spec=1.
  - Trigger vaddr 0x7F_FFFF_FFC0 → vaddr 0x0.
- Demand priority and starvation:
  - Queue one prefetch, then hold demand_v_i=1 with yumi every cycle.
  - Expect 7 demand grants (demand_yumi_o=1), then exactly one prefetch grant (demand_yumi_o=0, spec=1), then demand again.
- Force: same setup with demand_force_i=1 throughout → prefetch never issued; starve_cnt stays at 7 and the prefetch issues in the first cycle force drops.
- Full/drop:
  - Three distinct triggers 0x000, 0x100, 0x200 with no yumi → pf_count_o=2, pf_drop_o=1 on the third.
  - Repeat with a prefetch dequeue in the third cycle → no drop, count remains 2.
- Duplicate and flush:
  - Triggers 0x100 and 0x120 back-to-back → one entry (0x140).
  - flush_i together with a trigger → count 0, no drop pulse, starve_cnt 0.
- Reset mid-stream: queue two entries, then pull reset_n_i low for one cycle → all outputs 0 during reset; with demand idle afterward, icache_v_o stays 0.
